// File: rtl/set_bit_lister_if.sv
// Handshake bundle between the encoder stage, set_bit_lister and its downstream consumer.
// master = producer/consumer side, slave = set_bit_lister.
interface set_bit_lister_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned IDX_W = $clog2(W);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_word;
    logic [IDX_W-1:0] in_pe_out;
    logic             in_pe_valid;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_empty;
    logic [IDX_W:0]   out_seq;
    logic             chk_err;

    modport master (
        output in_valid, in_word, in_pe_out, in_pe_valid, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_empty, out_seq, chk_err
    );

    modport slave (
        input  in_valid, in_word, in_pe_out, in_pe_valid, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_empty, out_seq, chk_err
    );
endinterface

// File: rtl/set_bit_lister.sv
// Walks every set bit of an accepted word, emitting one index per beat, highest first.
// Optional SET_BIT_LISTER_CHECK_EN adds a sticky cross-check of the upstream priority encoder.
module set_bit_lister #(
    parameter int unsigned W = 8
) (
    input logic               clk,
    input logic               rst_n,
    set_bit_lister_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(W);
    localparam int unsigned SEQ_W = IDX_W + 1;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [SEQ_W-1:0] seq_q, seq_d;

    logic             accept;
    logic             beat;
    logic             out_valid;
    logic             out_last;
    logic             out_empty;
    logic [IDX_W-1:0] out_idx;
    logic [SEQ_W-1:0] out_seq;
    logic             in_ready;

    function automatic logic [IDX_W-1:0] msb_idx(input logic [W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Beat presentation is purely a function of the registered word, so it holds while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        out_seq   = '0;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            out_idx   = msb_idx(rem_q);
            out_last  = ((rem_q & (rem_q - W'(1))) == '0);
            out_empty = (rem_q == '0);
            out_seq   = seq_q;
        end
    end

    assign in_ready = (state_q == IDLE) | ((state_q == EMIT) & out_last & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign beat     = out_valid & bus.out_ready;

    // A new word accepted on the final beat overrides the drain, giving back-to-back words.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        if (beat) begin
            rem_d = rem_q & ~(W'(1) << out_idx);
            seq_d = seq_q + SEQ_W'(1);
            if (out_last) state_d = IDLE;
        end
        if (accept) begin
            rem_d   = bus.in_word;
            seq_d   = '0;
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
        end
    end

`ifdef SET_BIT_LISTER_CHECK_EN
    logic chk_err_q, chk_err_d;
    logic pe_mismatch;

    always_comb begin
        pe_mismatch = (bus.in_pe_valid != (bus.in_word != '0));
        if ((bus.in_word != '0) && (bus.in_pe_out != msb_idx(bus.in_word))) pe_mismatch = 1'b1;
    end

    always_comb begin
        chk_err_d = chk_err_q;
        if (accept && pe_mismatch) chk_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_err_q <= 1'b0;
        else        chk_err_q <= chk_err_d;
    end

    assign bus.chk_err = chk_err_q;
`else
    logic unused_pe;
    assign unused_pe   = ^{bus.in_pe_out, bus.in_pe_valid};
    assign bus.chk_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;
    assign bus.out_empty = out_empty;
    assign bus.out_seq   = out_seq;
endmodule

// File: tb/tb_set_bit_lister.sv
// Directed bench for set_bit_lister: drives and samples on the falling edge.
module tb_set_bit_lister;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    set_bit_lister_if #(.W(8)) bus ();

    set_bit_lister #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input int idx, input int last,
                               input int empty, input int seq);
        check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
        check_eq({tag, ".last"},  32'(bus.out_last),  32'(last));
        check_eq({tag, ".empty"}, 32'(bus.out_empty), 32'(empty));
        check_eq({tag, ".seq"},   32'(bus.out_seq),   32'(seq));
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".valid"},    32'(bus.out_valid), 32'd0);
        check_eq({tag, ".in_ready"}, 32'(bus.in_ready),  32'd1);
        check_eq({tag, ".idx"},      32'(bus.out_idx),   32'd0);
        check_eq({tag, ".seq"},      32'(bus.out_seq),   32'd0);
        check_eq({tag, ".last"},     32'(bus.out_last),  32'd0);
        check_eq({tag, ".empty"},    32'(bus.out_empty), 32'd0);
    endtask

    task automatic offer(input logic [7:0] w, input logic [2:0] pe, input logic pv);
        bus.in_valid    = 1'b1;
        bus.in_word     = w;
        bus.in_pe_out   = pe;
        bus.in_pe_valid = pv;
    endtask

    initial begin
        int a6_idx[4];
        int f0_rdy[6];
        int f0_idx[6];
        int f0_seq[6];
        a6_idx = '{7, 5, 2, 1};
        f0_rdy = '{1, 0, 0, 1, 1, 1};
        f0_idx = '{7, 6, 6, 6, 5, 4};
        f0_seq = '{0, 1, 1, 1, 2, 3};

        n_checks = 0;
        n_fail   = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_word     = '0;
        bus.in_pe_out   = '0;
        bus.in_pe_valid = 1'b0;
        bus.out_ready   = 1'b1;

        @(negedge clk);
        expect_idle("reset");
        check_eq("reset.chk_err", 32'(bus.chk_err), 32'd0);
        rst_n = 1'b1;

        // 1010_0110 -> 7,5,2,1
        @(negedge clk);
        offer(8'hA6, 3'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("a6[%0d]", i), a6_idx[i], (i == 3) ? 1 : 0, 0, i);
            @(negedge clk);
        end
        expect_idle("a6.done");
        check_eq("a6.chk_err", 32'(bus.chk_err), 32'd0);

        // zero word -> single empty beat
        offer(8'h00, 3'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_beat("zero", 0, 1, 1, 0);
        @(negedge clk);
        expect_idle("zero.done");

        // 0x81 then 0x10 back-to-back
        offer(8'h81, 3'd7, 1'b1);
        @(negedge clk);
        expect_beat("b2b[0]", 7, 0, 0, 0);
        check_eq("b2b[0].in_ready", 32'(bus.in_ready), 32'd0);
        offer(8'h10, 3'd4, 1'b1);
        @(negedge clk);
        expect_beat("b2b[1]", 0, 1, 0, 1);
        check_eq("b2b[1].in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_beat("b2b[2]", 4, 1, 0, 0);
        @(negedge clk);
        expect_idle("b2b.done");

        // 0xF0 with downstream stalls
        offer(8'hF0, 3'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = f0_rdy[i][0];
            #1;
            expect_beat($sformatf("f0[%0d]", i), f0_idx[i], (i == 5) ? 1 : 0, 0, f0_seq[i]);
            if (f0_rdy[i] == 0)
                check_eq($sformatf("f0[%0d].in_ready", i), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        expect_idle("f0.done");

        // wrong encoder result on 0x40
        offer(8'h40, 3'd3, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_beat("bad_pe", 6, 1, 0, 0);
`ifdef SET_BIT_LISTER_CHECK_EN
        check_eq("bad_pe.chk_err", 32'(bus.chk_err), 32'd1);
`else
        check_eq("bad_pe.chk_err", 32'(bus.chk_err), 32'd0);
`endif
        @(negedge clk);
        offer(8'h03, 3'd1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_beat("good_after", 1, 0, 0, 0);
`ifdef SET_BIT_LISTER_CHECK_EN
        check_eq("good_after.chk_err", 32'(bus.chk_err), 32'd1);
`else
        check_eq("good_after.chk_err", 32'(bus.chk_err), 32'd0);
`endif
        @(negedge clk);
        expect_beat("good_after[1]", 0, 1, 0, 1);
        @(negedge clk);
        expect_idle("good_after.done");

        // 0xFF interrupted by reset after three beats
        offer(8'hFF, 3'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_beat($sformatf("ff[%0d]", i), 7 - i, 0, 0, i);
            @(negedge clk);
        end
        expect_beat("ff[3]", 4, 0, 0, 3);
        rst_n = 1'b0;
        #1;
        expect_idle("ff.rst");
        check_eq("ff.rst.chk_err", 32'(bus.chk_err), 32'd0);
        @(negedge clk);
        expect_idle("ff.rst_hold");
        rst_n = 1'b1;
        offer(8'h02, 3'd1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_beat("post_rst", 1, 1, 0, 0);
        @(negedge clk);
        expect_idle("post_rst.done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
